// File: rtl/accum_bus_pkg.sv
// Opcodes, FSM state encoding and default widths shared by the
// accumulator processors and the operand memory on the op/data bus.
package accum_bus_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam int DEFAULT_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_F = 2'd1,
        ST_RESP_S = 2'd2
    } bus_state_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular operand buffer with registered read. An empty pop returns 0
// so a processor adding the result leaves the running sum unchanged.
module operand_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rptr    <= '0;
            wptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (pop) begin
                rd_data <= empty ? '0 : mem[rptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accumulator_memory.sv
// Bus slave holding the shared operand queue: answers FETCH/SEND with a
// one-cycle END response and flags when the reduction has finished.
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | buses released, accepting FETCH/SEND and preloads
// ST_RESP_F | driving op=END and the fetched word on data
// ST_RESP_S | driving op=END only, acknowledging a SEND
module accumulator_memory
    import accum_bus_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    inout  wire [1:0]     op,
    inout  wire [DW-1:0]  data,
    input  logic          load_en,
    input  logic [DW-1:0] load_data,
    output logic [AW:0]   count,
    output logic [AW+1:0] inflight,
    output logic          done,
    output logic          err
);

    bus_state_t    state_q;
    bus_state_t    state_d;
    logic          is_fetch;
    logic          is_send;
    logic          bus_free;
    logic          load_ok;
    logic          load_drop;
    logic          push;
    logic [DW-1:0] push_data;
    logic [DW-1:0] drive_q;
    logic          fifo_full;
    logic          fifo_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Anything other than FETCH/SEND in IDLE (NOP, a floating bus, a stray END) leaves the bus free for preloads.
    always_comb begin
        state_d  = state_q;
        is_fetch = 1'b0;
        is_send  = 1'b0;
        bus_free = 1'b0;
        if (state_q == ST_IDLE) begin
            case (op)
                OP_FETCH: begin
                    is_fetch = 1'b1;
                    state_d  = ST_RESP_F;
                end
                OP_SEND: begin
                    is_send = 1'b1;
                    state_d = ST_RESP_S;
                end
                default: bus_free = 1'b1;
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    assign load_ok   = load_en && bus_free;
    assign load_drop = load_en && !bus_free;
    assign push      = is_send || load_ok;
    assign push_data = is_send ? data : load_data;

    operand_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (is_fetch),
        .rd_data   (drive_q),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Each non-empty FETCH hands out one operand; each SEND retires a pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else if (is_fetch && !fifo_empty && (inflight != '1)) begin
            inflight <= inflight + 1'b1;
        end else if (is_send) begin
            inflight <= (inflight < (AW+2)'(2)) ? '0 : inflight - (AW+2)'(2);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            if ((push && fifo_full) || load_drop) begin
                err <= 1'b1;
            end
            if ((state_q == ST_IDLE) && (count == (AW+1)'(1)) && (inflight == '0)) begin
                done <= 1'b1;
            end
        end
    end

    assign op   = (state_q != ST_IDLE)   ? OP_END  : 'z;
    assign data = (state_q == ST_RESP_F) ? drive_q : 'z;

endmodule

// File: tb/tb_accumulator_memory.sv
// Bench for accumulator_memory: queue-level reference model checked every
// cycle, plus directed reductions, empty/full/wrap cases and async reset.
module tb_accumulator_memory;
    import accum_bus_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam logic [DW-1:0] RELEASED = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    op_drv = OP_NOP;
    logic          op_oe = 1'b0;
    logic [DW-1:0] data_drv = '0;
    logic          data_oe = 1'b0;
    logic          load_en = 1'b0;
    logic [DW-1:0] load_data = '0;
    wire  [1:0]    op_bus;
    wire  [DW-1:0] data_bus;
    logic [AW:0]   count;
    logic [AW+1:0] inflight;
    logic          done;
    logic          err;

    // Released buses read back as NOP on op and all-ones on data.
    assign op_bus   = op_oe   ? op_drv   : 2'bz;
    assign data_bus = data_oe ? data_drv : {DW{1'bz}};
    pulldown (op_bus);
    pullup (data_bus);

    accumulator_memory #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op_bus),
        .data      (data_bus),
        .load_en   (load_en),
        .load_data (load_data),
        .count     (count),
        .inflight  (inflight),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: queue of words plus a pending-response marker.
    typedef enum {R_NONE, R_FETCH, R_SEND} resp_e;
    resp_e         m_resp = R_NONE;
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_resp_data = '0;
    int            m_inflight = 0;
    bit            m_done = 1'b0;
    bit            m_err = 1'b0;

    function automatic void model_push(input logic [DW-1:0] w);
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_err = 1'b1;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        logic [1:0] bus_op;
        if (!reset_n) begin
            m_resp      = R_NONE;
            m_q.delete();
            m_resp_data = '0;
            m_inflight  = 0;
            m_done      = 1'b0;
            m_err       = 1'b0;
        end else begin
            if (m_resp == R_NONE && m_q.size() == 1 && m_inflight == 0) m_done = 1'b1;
            if (m_resp != R_NONE) begin
                if (load_en) m_err = 1'b1;
                m_resp = R_NONE;
            end else begin
                bus_op = op_oe ? op_drv : OP_NOP;
                if (bus_op == OP_FETCH) begin
                    if (load_en) m_err = 1'b1;
                    m_resp = R_FETCH;
                    if (m_q.size() > 0) begin
                        m_resp_data = m_q.pop_front();
                        if (m_inflight < 63) m_inflight++;
                    end else begin
                        m_resp_data = '0;
                    end
                end else if (bus_op == OP_SEND) begin
                    if (load_en) m_err = 1'b1;
                    m_resp = R_SEND;
                    model_push(data_drv);
                    m_inflight = (m_inflight >= 2) ? m_inflight - 2 : 0;
                end else if (load_en) begin
                    model_push(load_data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && check_en) begin
            check("op",       op_bus,   (m_resp != R_NONE) ? OP_END : OP_NOP);
            check("data",     data_bus, (m_resp == R_FETCH) ? m_resp_data : RELEASED);
            check("count",    count,    m_q.size());
            check("inflight", inflight, m_inflight);
            check("done",     done,     m_done);
            check("err",      err,      m_err);
        end
    end

    task automatic cycle(input logic [1:0] o, input logic [DW-1:0] d,
                         input logic le, input logic [DW-1:0] ld);
        @(negedge clk);
        #1;
        op_drv    = o;
        op_oe     = (o != OP_NOP);
        data_drv  = d;
        data_oe   = (o == OP_SEND);
        load_en   = le;
        load_data = ld;
        @(posedge clk);
        #1;
        op_oe   = 1'b0;
        data_oe = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] d);
        cycle(OP_NOP, '0, 1'b1, d);
    endtask

    task automatic fetch(output logic [DW-1:0] got);
        cycle(OP_FETCH, '0, 1'b0, '0);
        @(negedge clk);
        check("fetch_end", op_bus, OP_END);
        got = data_bus;
    endtask

    task automatic send(input logic [DW-1:0] d);
        cycle(OP_SEND, d, 1'b0, '0);
        @(negedge clk);
        check("send_end", op_bus, OP_END);
        check("send_data_released", data_bus, RELEASED);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        op_oe   = 1'b0;
        data_oe = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] words[DEPTH];
        logic [1:0]    o;
        int            r;

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_op", op_bus, OP_NOP);
        check("rst_data", data_bus, RELEASED);
        check_en = 1'b1;

        // Two-operand reduction
        load(32'd3);
        load(32'd5);
        fetch(a);
        check("a_fetch0", a, 32'd3);
        fetch(a);
        check("a_fetch1", a, 32'd5);
        send(32'd8);
        repeat (2) @(negedge clk);
        check("a_count", count, 1);
        check("a_inflight", inflight, 0);
        check("a_done", done, 1);

        // Full reduction of 1..8 by one processor
        do_reset();
        for (int i = 1; i <= 8; i++) load(DW'(i));
        for (int i = 0; i < 7; i++) begin
            fetch(a);
            fetch(b);
            send(a + b);
        end
        repeat (2) @(negedge clk);
        check("b_done", done, 1);
        check("b_count", count, 1);
        fetch(a);
        check("b_sum", a, 32'd36);

        // Empty fetch
        do_reset();
        fetch(a);
        check("c_empty_data", a, 32'd0);
        check("c_empty_count", count, 0);
        check("c_empty_inflight", inflight, 0);

        // Overflow on SEND
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            words[i] = $urandom;
            load(words[i]);
        end
        send(32'hDEADBEEF);
        check("d_err", err, 1);
        check("d_count", count, DEPTH);
        fetch(a);
        check("d_oldest", a, words[0]);

        // Pointer wrap-around
        do_reset();
        for (int i = 0; i < DEPTH; i++) load(DW'($urandom));
        for (int i = 0; i < 10; i++) begin
            fetch(a);
            fetch(b);
            send((a ^ b) + DW'(i));
        end

        // Async reset in the middle of a FETCH response
        do_reset();
        load(32'd7);
        load(32'd9);
        cycle(OP_FETCH, '0, 1'b0, '0);
        #2;
        reset_n = 1'b0;
        #1;
        check("f_op_released", op_bus, OP_NOP);
        check("f_data_released", data_bus, RELEASED);
        check("f_count", count, 0);
        check("f_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        fetch(a);
        check("f_fetch_after_rst", a, 32'd0);

        // Random traffic with colliding preloads
        do_reset();
        for (int i = 0; i < 400; i++) begin
            o = OP_NOP;
            if (m_resp == R_NONE) begin
                r = $urandom_range(0, 9);
                if (r < 4) o = OP_FETCH;
                else if (r < 7) o = OP_SEND;
            end
            cycle(o, DW'($urandom_range(0, 32'hFFFF)),
                  ($urandom_range(0, 3) == 0), DW'($urandom_range(0, 32'hFFFF)));
        end
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulator_memory.md
Name: accumulator_memory

Overview:
- Shared-bus memory slave that serves the accumulator processors.
- Holds a circular operand queue. A FETCH pops the oldest operand onto `data`; a SEND pushes the processor's result back into the queue.
- Sits directly on the processor-side `op`/`data` bus, downstream of the bus arbiter's grant.
- Asserts `done` once the queue reduces to a single word with no operand pairs outstanding.

Parameters:
- DEPTH, 16, number of queue entries; must be a power of two.
- AW, 4, pointer width; equals log2(DEPTH).
- DW, 32, data word width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op  inout  2  bus opcode: NOP=00, FETCH=01, SEND=10, END=11. This block drives only END.
- data  inout  DW  bus data. Driven by this block only while answering a FETCH.
- load_en  input  1  preload strobe from the testbench/host.
- load_data  input  DW  preload word.
- count  output  AW+1  number of valid entries in the queue.
- inflight  output  AW+2  FETCHes served minus 2×SENDs received.
- done  output  1  sticky flag: reduction complete.
- err  output  1  sticky flag: overflow or dropped load.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rptr=wptr=0; count=0; inflight=0; done=0; err=0.
  - `op` and `data` released to Z.
  - Queue contents are not cleared.
  - Reset in the middle of a response releases both buses immediately.
- States: IDLE, RESP_F, RESP_S.
- IDLE:
  - op==FETCH sampled at a rising edge →
    - drive register loads mem[rptr], or 0 if count==0;
    - if count>0: rptr++ (wraps), count--, inflight++;
    - next state RESP_F.
  - op==SEND sampled →
    - if count<DEPTH: mem[wptr]<=data, wptr++ (wraps), count++;
    - else: write dropped, err<=1;
    - inflight<=inflight-2, saturating at 0;
    - next state RESP_S.
  - op==NOP or Z with load_en=1 → same push as SEND, but inflight unchanged.
  - op==END in IDLE: ignored.
- RESP_F:
  - Drive op=END and data=drive register for exactly one cycle.
  - Then return to IDLE and release both buses to Z.
- RESP_S:
  - Drive op=END only; `data` stays Z.
  - One cycle, then return to IDLE.
- Latency: END is visible in the cycle after the edge that samples FETCH/SEND, i.e. one cycle.
  - This matches a requester that drives the opcode for one cycle and then waits for END.
- Request arbitration:
  - FETCH/SEND are accepted only in IDLE. Opcodes seen in RESP_* are ignored.
  - The arbiter guarantees a single master, so no requester queuing is needed.
  - load_en coinciding with a bus op or a RESP_* state → load dropped, err<=1.
- done: set at an edge when count==1 and inflight==0 and state==IDLE; cleared only by reset.
- Empty FETCH:
  - Returns 0, which is the additive identity, so the sum stays correct.
  - count and inflight are unchanged.
- Pointers wrap modulo DEPTH. count saturates at DEPTH (full) and never underflows.

Decomposition:
- Shared package `accum_bus_pkg`: opcode constants NOP/FETCH/SEND/END, default DW.
- Sub-module `operand_fifo`: circular buffer with push/pop, rptr/wptr/count, full/empty flags, registered read.
- accumulator_memory holds the bus FSM, tri-state drivers, inflight counter and done/err logic.

Test Plan:
- Preload 3,5 via load_en; FETCH → data=3 with op=END one cycle later; FETCH → data=5; SEND data=8 → END one cycle later; count=1, inflight=0, done=1.
- Preload 1..8 with one processor model looping → done=1 with the single entry equal to 36; `data` is Z in every non-RESP_F cycle.
- FETCH with count=0 → data=0 with END; count stays 0, inflight stays 0.
- Preload DEPTH words, then SEND 0xDEADBEEF → END still returned, err=1, count=DEPTH, oldest entry unchanged.
- Wrap-around: preload 16, 10×(FETCH,FETCH,SEND) → FIFO order preserved across the pointer wrap (verified against a reference queue model).
- reset_n low during RESP_F → op and data go Z immediately (asynchronously); count=0, done=0; a FETCH after reset returns 0.
